// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
package mult_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam logic OP_MULT    = 1'b0;
  localparam logic OP_DIV     = 1'b1;
  localparam int   ITER_COUNT = 32;
  localparam int   CNT_W      = 6;

  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mult_div_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on unsigned magnitudes.
// Accumulator layout: MULT {partial_hi, multiplier_shift}; DIV {remainder, dividend/quotient}.
module mult_div_core
  import mult_div_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_op,
  input  logic [31:0] i_mag_a,
  input  logic [31:0] i_mag_b,
  output logic [63:0] o_acc_next,
  output logic        o_last
);

  logic [63:0]      r_acc;
  logic [31:0]      r_b;
  logic [CNT_W-1:0] r_cnt;

  logic [32:0] w_sum;
  logic [32:0] w_rem_shift;
  logic [31:0] w_diff;
  logic        w_borrow;

  assign w_sum       = {1'b0, r_acc[63:32]} + {1'b0, r_b};
  assign w_rem_shift = r_acc[63:31];
  assign w_borrow    = (w_rem_shift < {1'b0, r_b});
  // Exact whenever there is no borrow, since the difference is then below the divisor.
  assign w_diff      = w_rem_shift[31:0] - r_b;
  assign o_last      = (r_cnt == CNT_W'(ITER_COUNT - 1));

  // Next accumulator value for one iteration of the selected operation.
  always_comb begin
    o_acc_next = r_acc;
    if (i_op == OP_MULT) begin
      if (r_acc[0]) begin
        o_acc_next = {w_sum, r_acc[31:1]};
      end else begin
        o_acc_next = {1'b0, r_acc[63:1]};
      end
    end else begin
      if (w_borrow) begin
        o_acc_next = {r_acc[62:0], 1'b0};
      end else begin
        o_acc_next = {w_diff, r_acc[30:0], 1'b1};
      end
    end
  end

  // Accumulator, divisor/multiplicand and iteration counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc <= 64'd0;
      r_b   <= 32'd0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_acc <= {32'd0, i_mag_a};
      r_b   <= i_mag_b;
      r_cnt <= '0;
    end else if (i_step) begin
      r_acc <= o_acc_next;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// Signed MULT/DIV controller: FSM, operand sign handling, result sign fix-up and HI/LO strobes.
// Optional feature macro: MULT_DIV_DIVZERO_EXC_EN (divide-by-zero short-circuits with a div_zero pulse).
module mult_div_ctrl
  import mult_div_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data,
  output logic        hi_write,
  output logic        lo_write,
  output logic        div_zero
);

  state_t      r_state;
  logic        r_op;
  logic        r_sa;
  logic        r_sb;
  logic        r_bzero;
  logic        r_busy;
  logic        r_done;
  logic        r_write;
  logic        r_dz;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_load;
  logic        w_step;
  logic        w_last;
  logic        w_dz_req;
  logic [63:0] w_acc_next;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_hi_res;
  logic [31:0] w_lo_res;

  assign w_load = start && (r_state == ST_IDLE);
  assign w_step = (r_state == ST_CALC);

`ifdef MULT_DIV_DIVZERO_EXC_EN
  assign w_dz_req = (op == OP_DIV) && (op_b == 32'd0);
`else
  assign w_dz_req = 1'b0;
`endif

  mult_div_core u_core (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_op       (r_op),
    .i_mag_a    (mag32(op_a)),
    .i_mag_b    (mag32(op_b)),
    .o_acc_next (w_acc_next),
    .o_last     (w_last)
  );

  // Sign-corrected results from the final iteration; quotient stays all-ones on a zero divisor.
  always_comb begin
    w_prod   = w_acc_next;
    w_quo    = w_acc_next[31:0];
    w_rem    = w_acc_next[63:32];
    w_hi_res = 32'd0;
    w_lo_res = 32'd0;
    if (r_sa ^ r_sb) begin
      w_prod = 64'd0 - w_acc_next;
    end else begin
      w_prod = w_acc_next;
    end
    if ((r_sa ^ r_sb) && !r_bzero) begin
      w_quo = 32'd0 - w_acc_next[31:0];
    end else begin
      w_quo = w_acc_next[31:0];
    end
    if (r_sa) begin
      w_rem = 32'd0 - w_acc_next[63:32];
    end else begin
      w_rem = w_acc_next[63:32];
    end
    if (r_op == OP_MULT) begin
      w_hi_res = w_prod[63:32];
      w_lo_res = w_prod[31:0];
    end else begin
      w_hi_res = w_rem;
      w_lo_res = w_quo;
    end
  end

  // Control FSM with registered status, strobes and result holding registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MULT;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_bzero <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_write <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done  <= 1'b0;
          r_write <= 1'b0;
          r_dz    <= 1'b0;
          if (start) begin
            r_op    <= op;
            r_sa    <= op_a[31];
            r_sb    <= op_b[31];
            r_bzero <= (op_b == 32'd0);
            r_busy  <= 1'b1;
            if (w_dz_req) begin
              r_state <= ST_FIX;
              r_done  <= 1'b1;
              r_dz    <= 1'b1;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (w_last) begin
            r_state <= ST_FIX;
            r_done  <= 1'b1;
            r_write <= 1'b1;
            r_hi    <= w_hi_res;
            r_lo    <= w_lo_res;
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_write <= 1'b0;
          r_dz    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_write <= 1'b0;
          r_dz    <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign hi_data  = r_hi;
  assign lo_data  = r_lo;
  assign hi_write = r_write;
  assign lo_write = r_write;
  assign div_zero = r_dz;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: reference results from native signed arithmetic.
module tb_mult_div_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic        hi_write;
  logic        lo_write;
  logic        div_zero;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  int   n_vec = 0;
  int   n_err = 0;
  res_t sb_q[$];
  res_t last_res;

  mult_div_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .hi_data  (hi_data),
    .lo_data  (lo_data),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  function automatic res_t model(input logic o, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    res_t   e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o) begin
      p = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  // Drive one start pulse (caller is at a falling edge) and record the expected write.
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b, input bit expect_write);
    op    = o;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    if (expect_write) sb_q.push_back(model(o, a, b));
  endtask

  // Wait for done; flags busy gaps, early strobes and disturbed HI/LO; scrambles inputs after start.
  task automatic wait_done(output int lat, output bit glitch);
    bit d;
    lat    = 0;
    glitch = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clock);
      d = (done === 1'b1);
      if (busy !== 1'b1) glitch = 1'b1;
      if (!d) begin
        if ((hi_write | lo_write | div_zero) !== 1'b0) glitch = 1'b1;
        if ({hi_data, lo_data} !== last_res) glitch = 1'b1;
      end
      start = 1'b0;
      op    = 1'($urandom);
      op_a  = $urandom;
      op_b  = $urandom;
      if (d) begin
        lat = j;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_vec++;
    if ({busy, done, hi_write, lo_write, div_zero} !== 5'b0 || hi_data !== 32'd0 || lo_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b wr=%b%b dz=%b hi=%h lo=%h, want all 0",
               busy, done, hi_write, lo_write, div_zero, hi_data, lo_data);
    end
    reset    = 1'b0;
    last_res = '0;
    @(negedge clock);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_mult;
    logic [31:0] av [8] = '{32'd6, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF,
                            32'h1234_5678, 32'h7FFF_FFFF, 32'd0, 32'd0};
    logic [31:0] bv [8] = '{32'd7, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF,
                            32'h9ABC_DEF0, 32'h8000_0000, 32'd0, 32'd0};
    res_t exp;
    int   lat;
    bit   gl;
    av[6] = $urandom; bv[6] = $urandom;
    av[7] = $urandom; bv[7] = $urandom;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, av[i], bv[i], 1'b1);
      wait_done(lat, gl);
      n_vec++;
      if (lat != 33) begin n_err++; $display("FAIL mult_latency[%0d]: got %0d want 33", i, lat); end
      n_vec++;
      if (gl) begin n_err++; $display("FAIL mult_busy_hold[%0d]: busy gap, early strobe or HI/LO changed", i); end
      n_vec++;
      if ({hi_write, lo_write, div_zero} !== 3'b110) begin
        n_err++; $display("FAIL mult_strobes[%0d]: got %b want 110", i, {hi_write, lo_write, div_zero});
      end
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++; $display("FAIL mult_scoreboard[%0d]: no expected entry", i);
      end else begin
        exp = sb_q.pop_front();
        if ({hi_data, lo_data} !== exp) begin
          n_err++; $display("FAIL mult_result[%0d]: got %h_%h want %h_%h", i, hi_data, lo_data, exp.hi, exp.lo);
        end
        last_res = exp;
      end
      if (i == 0) begin
        n_vec++;
        if ({hi_data, lo_data} !== 64'h0000_0000_0000_002A) begin
          n_err++; $display("FAIL mult_6x7: got %h_%h want 00000000_0000002a", hi_data, lo_data);
        end
      end
      if (i == 1) begin
        n_vec++;
        if ({hi_data, lo_data} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
          n_err++; $display("FAIL mult_m3x5: got %h_%h want ffffffff_fffffff1", hi_data, lo_data);
        end
      end
      @(negedge clock);
      n_vec++;
      if ({busy, done, hi_write, lo_write} !== 4'b0) begin
        n_err++; $display("FAIL mult_after[%0d]: busy/done/wr=%b want 0000", i, {busy, done, hi_write, lo_write});
      end
    end
  endtask

  task automatic test_div;
    logic [31:0] av [10] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'hFFFF_FF9C, 32'd100,
                             32'hFFFF_FF9C, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] bv [10] = '{32'd2, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'hFFFF_FFF9,
                             32'hFFFF_FFF9, 32'd100, 32'd1, 32'd0, 32'd0};
    res_t exp;
    int   lat;
    bit   gl;
    av[8] = $urandom; bv[8] = 32'($urandom_range(1000, 1));
    av[9] = $urandom; bv[9] = $urandom | 32'd1;
    for (int i = 0; i < 10; i++) begin
      issue(1'b1, av[i], bv[i], 1'b1);
      wait_done(lat, gl);
      n_vec++;
      if (lat != 33) begin n_err++; $display("FAIL div_latency[%0d]: got %0d want 33", i, lat); end
      n_vec++;
      if (gl) begin n_err++; $display("FAIL div_busy_hold[%0d]: busy gap, early strobe or HI/LO changed", i); end
      n_vec++;
      if ({hi_write, lo_write, div_zero} !== 3'b110) begin
        n_err++; $display("FAIL div_strobes[%0d]: got %b want 110", i, {hi_write, lo_write, div_zero});
      end
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++; $display("FAIL div_scoreboard[%0d]: no expected entry", i);
      end else begin
        exp = sb_q.pop_front();
        if ({hi_data, lo_data} !== exp) begin
          n_err++; $display("FAIL div_result[%0d]: got %h_%h want %h_%h", i, hi_data, lo_data, exp.hi, exp.lo);
        end
        last_res = exp;
      end
      if (i == 0) begin
        n_vec++;
        if ({hi_data, lo_data} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
          n_err++; $display("FAIL div_m7by2: got %h_%h want ffffffff_fffffffd", hi_data, lo_data);
        end
      end
      if (i == 1) begin
        n_vec++;
        if ({hi_data, lo_data} !== 64'h0000_0000_8000_0000) begin
          n_err++; $display("FAIL div_overflow: got %h_%h want 00000000_80000000", hi_data, lo_data);
        end
      end
      @(negedge clock);
      n_vec++;
      if ({busy, done, hi_write, lo_write} !== 4'b0) begin
        n_err++; $display("FAIL div_after[%0d]: busy/done/wr=%b want 0000", i, {busy, done, hi_write, lo_write});
      end
    end
  endtask

  task automatic test_divzero;
    logic [31:0] av [2] = '{32'd100, 32'hFFFF_FF9C};
    res_t exp;
    int   lat;
    bit   gl;
    for (int i = 0; i < 2; i++) begin
`ifdef MULT_DIV_DIVZERO_EXC_EN
      issue(1'b1, av[i], 32'd0, 1'b0);
      wait_done(lat, gl);
      n_vec++;
      if (lat != 1) begin n_err++; $display("FAIL dz_latency[%0d]: got %0d want 1", i, lat); end
      n_vec++;
      if ({busy, hi_write, lo_write, div_zero} !== 4'b1001) begin
        n_err++; $display("FAIL dz_pulse[%0d]: busy/wr/dz=%b want 1001", i, {busy, hi_write, lo_write, div_zero});
      end
      n_vec++;
      if ({hi_data, lo_data} !== last_res) begin
        n_err++; $display("FAIL dz_hold[%0d]: got %h_%h want %h_%h", i, hi_data, lo_data, last_res.hi, last_res.lo);
      end
`else
      issue(1'b1, av[i], 32'd0, 1'b1);
      wait_done(lat, gl);
      n_vec++;
      if (lat != 33) begin n_err++; $display("FAIL dz_latency[%0d]: got %0d want 33", i, lat); end
      n_vec++;
      if (gl || {hi_write, lo_write, div_zero} !== 3'b110) begin
        n_err++; $display("FAIL dz_strobes[%0d]: glitch=%b wr/dz=%b want 0/110", i, gl, {hi_write, lo_write, div_zero});
      end
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++; $display("FAIL dz_scoreboard[%0d]: no expected entry", i);
      end else begin
        exp = sb_q.pop_front();
        if ({hi_data, lo_data} !== exp) begin
          n_err++; $display("FAIL dz_result[%0d]: got %h_%h want %h_%h", i, hi_data, lo_data, exp.hi, exp.lo);
        end
        last_res = exp;
      end
      if (i == 0) begin
        n_vec++;
        if ({hi_data, lo_data} !== 64'h0000_0064_FFFF_FFFF) begin
          n_err++; $display("FAIL dz_100: got %h_%h want 00000064_ffffffff", hi_data, lo_data);
        end
      end
`endif
      @(negedge clock);
      n_vec++;
      if ({busy, done, hi_write, lo_write, div_zero} !== 5'b0) begin
        n_err++; $display("FAIL dz_after[%0d]: busy/done/wr/dz=%b want 00000", i, {busy, done, hi_write, lo_write, div_zero});
      end
    end
  endtask

  task automatic test_back_to_back;
    res_t exp;
    int   lat;
    bit   gl;
    issue(1'b0, 32'd1000, 32'hFFFF_FFFD, 1'b1);
    wait_done(lat, gl);
    n_vec++;
    if (lat != 33 || gl) begin n_err++; $display("FAIL b2b_first: lat=%0d glitch=%b want 33/0", lat, gl); end
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++; $display("FAIL b2b_scoreboard_a: no expected entry");
    end else begin
      exp = sb_q.pop_front();
      if ({hi_data, lo_data} !== exp) begin
        n_err++; $display("FAIL b2b_result_a: got %h_%h want %h_%h", hi_data, lo_data, exp.hi, exp.lo);
      end
      last_res = exp;
    end
    @(negedge clock);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle34: busy=%b want 0", busy); end
    issue(1'b1, 32'hFFFF_FC18, 32'd7, 1'b1);
    wait_done(lat, gl);
    n_vec++;
    if (lat != 33) begin n_err++; $display("FAIL b2b_latency: got %0d want 33 (cycle 67)", lat); end
    n_vec++;
    if (gl) begin n_err++; $display("FAIL b2b_hold: previous HI/LO not held or early strobe"); end
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++; $display("FAIL b2b_scoreboard_b: no expected entry");
    end else begin
      exp = sb_q.pop_front();
      if ({hi_data, lo_data} !== exp || {hi_write, lo_write} !== 2'b11) begin
        n_err++; $display("FAIL b2b_result_b: got %h_%h wr=%b want %h_%h wr=11",
                          hi_data, lo_data, {hi_write, lo_write}, exp.hi, exp.lo);
      end
      last_res = exp;
    end
    @(negedge clock);
  endtask

  task automatic test_abort;
    bit early_bad = 1'b0;
    bit late_bad  = 1'b0;
    issue(1'b0, 32'd1234, 32'd5678, 1'b0);
    for (int j = 1; j <= 40; j++) begin
      @(negedge clock);
      if (j <= 10 && (busy !== 1'b1 || done !== 1'b0 || hi_write !== 1'b0)) early_bad = 1'b1;
      if (j >= 11 && ({busy, done, hi_write, lo_write, div_zero} !== 5'b0 ||
                      hi_data !== 32'd0 || lo_data !== 32'd0)) late_bad = 1'b1;
      start = (j == 5);
      if (j == 5) begin
        op   = 1'b1;
        op_a = 32'd9;
        op_b = 32'd3;
      end
      reset = (j == 10);
    end
    n_vec++;
    if (early_bad) begin n_err++; $display("FAIL abort_running: busy not steady in cycles 1-10"); end
    n_vec++;
    if (late_bad) begin n_err++; $display("FAIL abort_quiet: activity or nonzero HI/LO in cycles 11-40"); end
    last_res = '0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    op_a  = 32'd0;
    op_b  = 32'd0;
    test_reset;
    test_mult;
    test_div;
    test_divzero;
    test_back_to_back;
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports are named clock and reset.
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
  clock     in   1   rising-edge clock
  reset     in   1   synchronous active-high reset
  start     in   1   begin operation; sampled only in IDLE
  op        in   1   0 = MULT, 1 = DIV (signed)
  op_a      in   32  multiplicand / dividend (regA)
  op_b      in   32  multiplier / divisor (regB)
  busy      out  1   operation in progress
  done      out  1   single-cycle completion pulse
  hi_data   out  32  value for HI register
  lo_data   out  32  value for LO register
  hi_write  out  1   HI load strobe
  lo_write  out  1   LO load strobe
  div_zero  out  1   divide-by-zero pulse

Function
REQ-003 States SHALL be IDLE, CALC and FIX; IDLE->CALC on start, CALC->FIX after exactly 32 iterations, FIX->IDLE unconditionally.
REQ-004 On start, the block SHALL latch op, the sign of op_a and op_b, and their unsigned magnitudes; later changes to the inputs SHALL have no effect.
REQ-005 MULT SHALL be shift-add on the magnitudes, one bit per CALC cycle, producing a 64-bit magnitude.
REQ-006 DIV SHALL be restoring division on the magnitudes, one quotient bit per CALC cycle, producing a 32-bit quotient and a 32-bit remainder.
REQ-007 In FIX, sign correction SHALL apply: product sign = sA^sB (64-bit negate); quotient sign = sA^sB; remainder sign = sA.
REQ-008 For MULT, hi_data/lo_data SHALL be product[63:32]/[31:0]; for DIV, hi_data = remainder and lo_data = quotient.
REQ-009 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0; no error is flagged.
REQ-010 Timing: if start is high in cycle 0, busy SHALL be high in cycles 1-33, and done, hi_write and lo_write SHALL be high in cycle 33 only.
REQ-011 hi_data/lo_data SHALL hold their last result until the next FIX.
REQ-012 A start asserted while busy SHALL be ignored, not queued.
REQ-013 hi_write and lo_write SHALL always assert together.

Reset
REQ-014 While reset is high, the block SHALL return to IDLE; busy, done, hi_write, lo_write and div_zero SHALL be 0; hi_data and lo_data SHALL be 0.
REQ-015 A reset during CALC or FIX SHALL abort the operation with no write strobe in any later cycle.

Configuration
REQ-016 With MULT_DIV_DIVZERO_EXC_EN defined, a DIV with op_b = 0 SHALL skip CALC: div_zero and done pulse in cycle 1, busy is high in cycle 1, no HI/LO write occurs, and the block returns to IDLE.
REQ-017 Without MULT_DIV_DIVZERO_EXC_EN, div_zero SHALL be tied to 0 and a DIV by zero SHALL run the normal 33-cycle timing, writing HI = op_a and LO = 0xFFFFFFFF.

Structure
REQ-018 The shared package mult_div_pkg SHALL hold the state enum, the op encoding (OP_MULT = 0, OP_DIV = 1) and ITER_COUNT = 32.
REQ-019 The per-iteration datapath (shift-add / restore step on the accumulator, remainder and count) SHALL be a sub-module named mult_div_core; mult_div_ctrl owns the FSM, sign handling and the strobes.

Verification
REQ-020 MULT 6 x 7, start in cycle 0 -> cycle 33: done = 1, hi_data = 0x00000000, lo_data = 0x0000002A, both strobes high; busy low from cycle 34.
REQ-021 MULT -3 x 5 -> hi_data = 0xFFFFFFFF, lo_data = 0xFFFFFFF1.
REQ-022 DIV -7 / 2 -> lo_data = 0xFFFFFFFD, hi_data = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo_data = 0x80000000, hi_data = 0.
REQ-023 DIV 100 / 0 -> with macro: div_zero and done in cycle 1, no strobes; without macro: cycle 33 gives hi_data = 100, lo_data = 0xFFFFFFFF.
REQ-024 Start MULT, pulse start again with new operands in cycle 5, assert reset in cycle 10 -> the cycle-5 start is ignored; after reset, busy = 0 and no strobe appears in cycles 11-40.
REQ-025 Back-to-back operations: a new start in cycle 34 -> accepted; the previous hi_data/lo_data are held until the new FIX in cycle 67.
